// File: rtl/lvds_rx_pkg.sv
// Shared constants for the LVDS pixel unpacker: lane bit positions for both
// bit mappings, default counter widths and the timing-measurement FSM states.
package lvds_rx_pkg;

  localparam int unsigned DEF_HW = 12;
  localparam int unsigned DEF_VW = 11;

  // Element [i] is the flat lane_data index (7*lane + bit) carrying colour bit i.
  typedef logic [7:0][4:0] lane_pos_t;

  localparam lane_pos_t VESA_R_POS  = {5'd22, 5'd21, 5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0};
  localparam lane_pos_t VESA_G_POS  = {5'd24, 5'd23, 5'd11, 5'd10, 5'd9,  5'd8,  5'd7,  5'd6};
  localparam lane_pos_t VESA_B_POS  = {5'd26, 5'd25, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12};

  localparam lane_pos_t JEIDA_R_POS = {5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0,  5'd22, 5'd21};
  localparam lane_pos_t JEIDA_G_POS = {5'd11, 5'd10, 5'd9,  5'd8,  5'd7,  5'd6,  5'd24, 5'd23};
  localparam lane_pos_t JEIDA_B_POS = {5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd26, 5'd25};

  localparam int unsigned HS_POS   = 18;
  localparam int unsigned VS_POS   = 19;
  localparam int unsigned DE_POS   = 20;
  localparam int unsigned RSVD_POS = 27;

  typedef enum logic [1:0] {
    StIdle,
    StWaitDe,
    StMeasure
  } meas_state_e;

endpackage

// File: rtl/lvds_timing_meas.sv
// Measures line total, line active width and active lines per frame from the
// decoded VS/DE stream and declares lock after consecutive identical frames.
module lvds_timing_meas
  import lvds_rx_pkg::*;
#(
  parameter int unsigned HW          = DEF_HW,
  parameter int unsigned VW          = DEF_VW,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          px_clk,
  input  logic          px_reset,
  input  logic          valid,
  input  logic          vs,
  input  logic          de,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_active,
  output logic          timing_locked,
  output logic          timing_err
);

  localparam int unsigned LCW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_FRAMES - 1);

  meas_state_e   state;
  logic          vs_q, de_q;
  logic [HW-1:0] h_cnt, act_cnt, ref_total, ref_active;
  logic [VW-1:0] line_cnt;
  logic          mismatch, prev_good;
  logic [LCW-1:0] lock_cnt;

  logic          vs_rise, de_rise, frame_match, sat;
  logic [LCW-1:0] lock_next;

  assign vs_rise = vs & ~vs_q;
  assign de_rise = de & ~de_q;

  // A frame counts toward lock only if it and the frame before it were both clean.
  assign frame_match = !mismatch && prev_good && (ref_total == h_total) &&
                       (ref_active == h_active) && (line_cnt == v_active);
  assign lock_next   = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

  // Vertical blanking may legitimately run h_cnt to its ceiling, so the h counter
  // only counts as saturated when its value would be captured as a line total.
  assign sat = (act_cnt == '1) || (line_cnt == '1) || (de_rise && (h_cnt == '1));

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      state         <= StIdle;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      h_cnt         <= '0;
      act_cnt       <= '0;
      line_cnt      <= '0;
      ref_total     <= '0;
      ref_active    <= '0;
      mismatch      <= 1'b0;
      prev_good     <= 1'b0;
      lock_cnt      <= '0;
      h_total       <= '0;
      h_active      <= '0;
      v_active      <= '0;
      timing_locked <= 1'b0;
      timing_err    <= 1'b0;
    end else begin
      vs_q <= vs;
      de_q <= de;
      if (!valid) begin
        state         <= StIdle;
        mismatch      <= 1'b0;
        prev_good     <= 1'b0;
        lock_cnt      <= '0;
        timing_locked <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (vs_rise) state <= StWaitDe;
          end
          StWaitDe: begin
            h_cnt      <= '0;
            act_cnt    <= '0;
            line_cnt   <= '0;
            ref_total  <= '0;
            ref_active <= '0;
            mismatch   <= 1'b0;
            if (vs_rise) begin
              // Frame without any DE line.
              h_total       <= '0;
              h_active      <= '0;
              v_active      <= '0;
              prev_good     <= 1'b0;
              lock_cnt      <= '0;
              timing_locked <= 1'b0;
            end else if (de_rise) begin
              h_cnt    <= HW'(1);
              act_cnt  <= HW'(1);
              line_cnt <= VW'(1);
              state    <= StMeasure;
            end
          end
          StMeasure: begin
            if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;
            if (de && (act_cnt != '1)) act_cnt <= act_cnt + 1'b1;
            if (vs_rise) begin
              h_total   <= ref_total;
              h_active  <= ref_active;
              v_active  <= line_cnt;
              prev_good <= !mismatch;
              mismatch  <= 1'b0;
              if (frame_match) begin
                lock_cnt      <= lock_next;
                timing_locked <= (lock_next == LOCK_MAX);
              end else begin
                lock_cnt      <= '0;
                timing_locked <= 1'b0;
              end
              if (de_rise) begin
                // DE rising together with VS opens line 1 of the next frame.
                h_cnt      <= HW'(1);
                act_cnt    <= HW'(1);
                line_cnt   <= VW'(1);
                ref_total  <= '0;
                ref_active <= '0;
              end else begin
                state <= StWaitDe;
              end
            end else if (de_rise) begin
              h_cnt   <= HW'(1);
              act_cnt <= HW'(1);
              if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
              if (line_cnt == VW'(1)) begin
                ref_total  <= h_cnt;
                ref_active <= act_cnt;
              end else if ((h_cnt != ref_total) || (act_cnt != ref_active)) begin
                mismatch <= 1'b1;
              end
            end
            if (sat) begin
              timing_err    <= 1'b1;
              prev_good     <= 1'b0;
              lock_cnt      <= '0;
              timing_locked <= 1'b0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/lvds_pixel_unpack.sv
// Unpacks aligned 7-bit LVDS lane words into RGB888 + HS/VS/DE with a fixed
// two-cycle pipeline, and measures the incoming frame timing.
module lvds_pixel_unpack
  import lvds_rx_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 4,
  parameter bit          MAP_JEIDA   = 1'b0,
  parameter bit          HS_POL      = 1'b1,
  parameter bit          VS_POL      = 1'b1,
  parameter int unsigned HW          = DEF_HW,
  parameter int unsigned VW          = DEF_VW,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                   px_clk,
  input  logic                   px_reset,
  input  logic                   px_ready,
  input  logic [7*NUM_LANES-1:0] lane_data,
  output logic [23:0]            rgb_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   de_out,
  output logic                   out_valid,
  output logic [HW-1:0]          h_total,
  output logic [HW-1:0]          h_active,
  output logic [VW-1:0]          v_active,
  output logic                   timing_locked,
  output logic                   timing_err
);

  localparam lane_pos_t R_POS = MAP_JEIDA ? JEIDA_R_POS : VESA_R_POS;
  localparam lane_pos_t G_POS = MAP_JEIDA ? JEIDA_G_POS : VESA_G_POS;
  localparam lane_pos_t B_POS = MAP_JEIDA ? JEIDA_B_POS : VESA_B_POS;

  logic [23:0] map_rgb;
  logic [23:0] s1_rgb;
  logic        s1_hs, s1_vs, s1_de, s1_valid;
  logic        meas_valid;
  logic        unused_rsvd;

  assign unused_rsvd = lane_data[RSVD_POS];

  always_comb begin
    map_rgb = '0;
    for (int i = 0; i < 8; i++) begin
      map_rgb[16+i] = lane_data[R_POS[i]];
      map_rgb[8+i]  = lane_data[G_POS[i]];
      map_rgb[i]    = lane_data[B_POS[i]];
    end
  end

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      s1_valid  <= 1'b0;
      s1_rgb    <= '0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_de     <= 1'b0;
      out_valid <= 1'b0;
      rgb_out   <= '0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      s1_valid  <= px_ready;
      s1_rgb    <= map_rgb;
      s1_hs     <= lane_data[HS_POS] ^ ~HS_POL;
      s1_vs     <= lane_data[VS_POS] ^ ~VS_POL;
      s1_de     <= lane_data[DE_POS];
      out_valid <= s1_valid;
      rgb_out   <= s1_valid ? s1_rgb : '0;
      hs_out    <= s1_valid & s1_hs;
      vs_out    <= s1_valid & s1_vs;
      de_out    <= s1_valid & s1_de;
    end
  end

  // Hold the measurement idle whenever either pipeline stage carries invalid data.
  assign meas_valid = s1_valid & out_valid;

  lvds_timing_meas #(
    .HW          (HW),
    .VW          (VW),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_meas (
    .px_clk        (px_clk),
    .px_reset      (px_reset),
    .valid         (meas_valid),
    .vs            (s1_vs),
    .de            (s1_de),
    .h_total       (h_total),
    .h_active      (h_active),
    .v_active      (v_active),
    .timing_locked (timing_locked),
    .timing_err    (timing_err)
  );

endmodule

// File: tb/tb_lvds_pixel_unpack.sv
// Directed bench for lvds_pixel_unpack: reset/gating, VESA mapping, timing
// lock, mismatch, mid-frame drop and counter saturation on a reduced raster.
module tb_lvds_pixel_unpack;

  localparam int HT = 24;
  localparam int HA = 16;
  localparam int VT = 12;
  localparam int VA = 8;

  logic        px_clk = 1'b0;
  logic        px_reset;
  logic        px_ready;
  logic [27:0] lane_data;
  logic [23:0] rgb_out;
  logic        hs_out, vs_out, de_out, out_valid;
  logic [11:0] h_total, h_active;
  logic [10:0] v_active;
  logic        timing_locked, timing_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Target bit in {rgb_out, hs_out, vs_out, de_out} for each lane_data bit (VESA).
  int vesa_dst [28] = '{19, 20, 21, 22, 23, 24, 11, 12, 13, 14, 15, 16, 3, 4,
                        5, 6, 7, 8, 2, 1, 0, 25, 26, 17, 18, 9, 10, -1};

  lvds_pixel_unpack #(
    .NUM_LANES   (4),
    .MAP_JEIDA   (1'b0),
    .HS_POL      (1'b1),
    .VS_POL      (1'b1),
    .HW          (12),
    .VW          (11),
    .LOCK_FRAMES (2)
  ) dut (
    .px_clk        (px_clk),
    .px_reset      (px_reset),
    .px_ready      (px_ready),
    .lane_data     (lane_data),
    .rgb_out       (rgb_out),
    .hs_out        (hs_out),
    .vs_out        (vs_out),
    .de_out        (de_out),
    .out_valid     (out_valid),
    .h_total       (h_total),
    .h_active      (h_active),
    .v_active      (v_active),
    .timing_locked (timing_locked),
    .timing_err    (timing_err)
  );

  always #5 px_clk = ~px_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge px_clk);
  endtask

  function automatic logic [27:0] px_word(input logic hs, input logic vs, input logic de,
                                          input logic [6:0] pix);
    logic [27:0] w;
    w        = {pix, pix, 7'h00, pix ^ 7'h2a};
    w[17:14] = pix[3:0];
    w[18]    = hs;
    w[19]    = vs;
    w[20]    = de;
    return w;
  endfunction

  // One raster frame; VS occupies line VA+1. short_line loses one cycle,
  // and the task returns mid-DE of stop_line when that line is reached.
  task automatic drive_frame(input int short_line, input int stop_line);
    for (int ln = 0; ln < VT; ln++) begin
      int len;
      len = (ln == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        if (ln == stop_line && c == HA / 2) return;
        lane_data = px_word((c >= HA + 2) && (c < HA + 5), ln == VA + 1,
                            (ln < VA) && (c < HA), 7'(c + ln));
        @(negedge px_clk);
      end
    end
  endtask

  initial begin
    px_reset  = 1'b1;
    px_ready  = 1'b0;
    lane_data = 28'habcdef1;
    tick(3);
    px_reset = 1'b0;
    tick(3);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst rgb", 32'(rgb_out), 32'd0);
    check_eq("rst hs/vs/de", 32'({hs_out, vs_out, de_out}), 32'd0);
    check_eq("rst h_total", 32'(h_total), 32'd0);
    check_eq("rst v_active", 32'(v_active), 32'd0);
    check_eq("rst lock/err", 32'({timing_locked, timing_err}), 32'd0);

    // Gating release and VESA vector.
    px_ready  = 1'b1;
    lane_data = {7'h00, 7'h70, 7'h60, 7'h41};
    tick(1);
    check_eq("valid after 1", 32'(out_valid), 32'd0);
    check_eq("rgb after 1", 32'(rgb_out), 32'd0);
    tick(1);
    check_eq("valid after 2", 32'(out_valid), 32'd1);
    check_eq("vesa rgb", 32'(rgb_out), 32'h010103);
    check_eq("vesa hs/vs/de", 32'({hs_out, vs_out, de_out}), 32'h7);

    for (int i = 0; i < 28; i++) begin
      logic [26:0] exp;
      lane_data = 28'h1 << i;
      tick(2);
      exp = (vesa_dst[i] < 0) ? 27'h0 : (27'h1 << vesa_dst[i]);
      check_eq($sformatf("walk%0d", i), 32'({rgb_out, hs_out, vs_out, de_out}), 32'(exp));
    end

    // Start the timing tests from a known idle state.
    px_ready  = 1'b0;
    lane_data = 28'h0;
    tick(4);
    px_ready = 1'b1;
    tick(2);

    drive_frame(-1, -1);
    drive_frame(-1, -1);
    check_eq("f1 h_total", 32'(h_total), HT);
    check_eq("f1 h_active", 32'(h_active), HA);
    check_eq("f1 v_active", 32'(v_active), VA);
    check_eq("f1 unlocked", 32'(timing_locked), 32'd0);
    drive_frame(-1, -1);
    check_eq("f2 locked", 32'(timing_locked), 32'd1);
    check_eq("f2 h_total", 32'(h_total), HT);

    drive_frame(3, -1);
    check_eq("short unlocked", 32'(timing_locked), 32'd0);
    check_eq("short h_total", 32'(h_total), HT);
    drive_frame(-1, -1);
    check_eq("clean1 unlocked", 32'(timing_locked), 32'd0);
    drive_frame(-1, -1);
    check_eq("clean2 relocked", 32'(timing_locked), 32'd1);

    // Drop px_ready in the middle of an active line.
    drive_frame(-1, 4);
    check_eq("pre-drop de", 32'(de_out), 32'd1);
    px_ready = 1'b0;
    tick(2);
    check_eq("drop valid", 32'(out_valid), 32'd0);
    check_eq("drop rgb/de", 32'({rgb_out, de_out}), 32'd0);
    check_eq("drop unlocked", 32'(timing_locked), 32'd0);
    check_eq("drop h_total held", 32'(h_total), HT);
    check_eq("drop h_active held", 32'(h_active), HA);
    check_eq("drop v_active held", 32'(v_active), VA);

    lane_data = 28'h0;
    px_ready  = 1'b1;
    tick(2);
    drive_frame(-1, -1);
    drive_frame(-1, -1);
    drive_frame(-1, -1);
    check_eq("relock after drop", 32'(timing_locked), 32'd1);
    check_eq("no err yet", 32'(timing_err), 32'd0);

    // DE held high long enough to saturate the counters.
    lane_data = px_word(1'b0, 1'b0, 1'b1, 7'h11);
    tick(4100);
    lane_data = px_word(1'b0, 1'b0, 1'b0, 7'h00);
    tick(3);
    check_eq("sat err", 32'(timing_err), 32'd1);
    check_eq("sat unlocked", 32'(timing_locked), 32'd0);
    drive_frame(-1, -1);
    drive_frame(-1, -1);
    drive_frame(-1, -1);
    check_eq("err sticky", 32'(timing_err), 32'd1);

    px_reset = 1'b1;
    tick(1);
    px_reset = 1'b0;
    tick(1);
    check_eq("reset clears err", 32'(timing_err), 32'd0);
    check_eq("reset h_total", 32'(h_total), 32'd0);
    check_eq("reset v_active", 32'(v_active), 32'd0);
    check_eq("reset locked", 32'(timing_locked), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
